// File: rtl/adc_c2h_packer.sv
// Packs ADC sample sets into 128-bit AXI-Stream beats (4 sign-extended 32-bit lanes per beat),
// groups them into tlast-delimited packets, and buffers beats in a FIFO against host backpressure.
module adc_c2h_packer #(
  parameter int ADC_CHANNELS   = 4,
  parameter int ADC_DATA_WIDTH = 18,
  parameter int C_DATA_WIDTH   = 128,
  parameter int PKT_SAMPLES    = 256,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                                   axi_aclk,
  input  logic                                   rst,
  input  logic                                   acq_en,
  input  logic                                   sample_valid,
  input  logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_data_arr,
  output logic [C_DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]              m_axis_tkeep,
  output logic                                   m_axis_tlast,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic                                   overflow,
  output logic [31:0]                            sample_cnt
);

  localparam int BEATS  = (ADC_CHANNELS + 3) / 4;
  localparam int SNAP_W = BEATS * 4 * ADC_DATA_WIDTH;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW     = $clog2(PKT_SAMPLES);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int EW     = C_DATA_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, SER, TERM} state_t;

  state_t                    state, next_state;
  logic                      acq_en_d, acq_rise, acq_fall;
  logic [SNAP_W-1:0]         snap;
  logic [BIDX_W-1:0]         beat_idx;
  logic                      last_beat, term_pend;
  logic [PW-1:0]             pkt_cnt;
  logic                      accept, drop, set_done, term_push;
  logic [C_DATA_WIDTH-1:0]   beat_data;
  logic [ADC_DATA_WIDTH-1:0] lane_s;

  logic [EW-1:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [AW:0]               count;
  logic                      push, pop, has_room, fifo_full;
  logic [EW-1:0]             push_entry;

  assign acq_rise  = acq_en & ~acq_en_d;
  assign acq_fall  = ~acq_en & acq_en_d;
  assign last_beat = (beat_idx == BIDX_W'(BEATS - 1));
  // Room is judged on the registered count, so a whole set always fits once accepted.
  assign has_room  = (count <= (AW+1)'(FIFO_DEPTH - BEATS));
  assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));

  // Snapshot is zero-padded to whole beats, so unused lanes sign-extend to zero.
  always_comb begin
    beat_data = '0;
    lane_s    = '0;
    for (int unsigned l = 0; l < 4; l++) begin
      lane_s = snap[(32'(beat_idx) * 4 + l) * ADC_DATA_WIDTH +: ADC_DATA_WIDTH];
      beat_data[32*l +: 32] = {{(32-ADC_DATA_WIDTH){lane_s[ADC_DATA_WIDTH-1]}}, lane_s};
    end
  end

  always_comb begin
    next_state = state;
    push       = 1'b0;
    push_entry = '0;
    accept     = 1'b0;
    drop       = 1'b0;
    set_done   = 1'b0;
    term_push  = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid && acq_en) begin
          if (has_room) begin
            accept     = 1'b1;
            next_state = SER;
          end else begin
            drop = 1'b1;
          end
        end else if (acq_fall && pkt_cnt != '0) begin
          next_state = TERM;
        end
      end
      SER: begin
        push       = 1'b1;
        push_entry = {last_beat && (pkt_cnt == PW'(PKT_SAMPLES - 1)), beat_data};
        if (sample_valid && acq_en) drop = 1'b1;
        if (last_beat) begin
          set_done = 1'b1;
          if ((term_pend || acq_fall) && pkt_cnt != PW'(PKT_SAMPLES - 1)) next_state = TERM;
          else next_state = IDLE;
        end
      end
      TERM: begin
        if (!fifo_full) begin
          push       = 1'b1;
          term_push  = 1'b1;
          push_entry = {1'b1, {C_DATA_WIDTH{1'b0}}};
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      state      <= IDLE;
      acq_en_d   <= 1'b0;
      snap       <= '0;
      beat_idx   <= '0;
      term_pend  <= 1'b0;
      pkt_cnt    <= '0;
      sample_cnt <= '0;
      overflow   <= 1'b0;
    end else begin
      state    <= next_state;
      acq_en_d <= acq_en;
      if (accept) begin
        snap     <= SNAP_W'(adc_data_arr);
        beat_idx <= '0;
      end else if (state == SER) begin
        beat_idx <= last_beat ? '0 : beat_idx + BIDX_W'(1);
      end
      term_pend <= (state == SER && !last_beat) ? (term_pend | acq_fall) : 1'b0;
      if (set_done) begin
        sample_cnt <= sample_cnt + 32'd1;
        pkt_cnt    <= pkt_cnt + PW'(1);
      end
      if (term_push) pkt_cnt <= '0;
      if (acq_rise) begin
        sample_cnt <= '0;
        pkt_cnt    <= '0;
        overflow   <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  assign pop = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr][C_DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & mem[rd_ptr][C_DATA_WIDTH];
  assign m_axis_tkeep  = m_axis_tvalid ? '1 : '0;

endmodule

// File: tb/tb_adc_c2h_packer.sv
// Self-checking bench: a 4-channel and a 6-channel packer (4 sets per packet, 16-beat FIFO)
// compared against a queue-based model of the beat/packet stream.
module tb_adc_c2h_packer;

  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         acq_a, sv_a, tl_a, tv_a, tr_a, ov_a;
  logic [71:0]  adc_a;
  logic [127:0] td_a;
  logic [15:0]  tk_a;
  logic [31:0]  sc_a;
  logic         acq_b, sv_b, tl_b, tv_b, tr_b, ov_b;
  logic [107:0] adc_b;
  logic [127:0] td_b;
  logic [15:0]  tk_b;
  logic [31:0]  sc_b;

  int checks = 0;
  int failures = 0;

  logic [144:0] obs_a[$], obs_b[$], exp_a[$], exp_b[$];
  int m_pkt[2];

  always #5 clk = ~clk;

  adc_c2h_packer #(.ADC_CHANNELS(4), .ADC_DATA_WIDTH(18), .C_DATA_WIDTH(128),
                   .PKT_SAMPLES(P), .FIFO_DEPTH(16)) dut_a (
    .axi_aclk(clk), .rst(rst), .acq_en(acq_a), .sample_valid(sv_a), .adc_data_arr(adc_a),
    .m_axis_tdata(td_a), .m_axis_tkeep(tk_a), .m_axis_tlast(tl_a), .m_axis_tvalid(tv_a),
    .m_axis_tready(tr_a), .overflow(ov_a), .sample_cnt(sc_a));

  adc_c2h_packer #(.ADC_CHANNELS(6), .ADC_DATA_WIDTH(18), .C_DATA_WIDTH(128),
                   .PKT_SAMPLES(P), .FIFO_DEPTH(16)) dut_b (
    .axi_aclk(clk), .rst(rst), .acq_en(acq_b), .sample_valid(sv_b), .adc_data_arr(adc_b),
    .m_axis_tdata(td_b), .m_axis_tkeep(tk_b), .m_axis_tlast(tl_b), .m_axis_tvalid(tv_b),
    .m_axis_tready(tr_b), .overflow(ov_b), .sample_cnt(sc_b));

  // Record every handshaked beat; it leaves the FIFO on the following rising edge.
  always @(negedge clk) begin
    if (!rst && tv_a && tr_a) obs_a.push_back({tl_a, tk_a, td_a});
    if (!rst && tv_b && tr_b) obs_b.push_back({tl_b, tk_b, td_b});
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    acq_a = 1'b0; sv_a = 1'b0; adc_a = '0; tr_a = 1'b1;
    acq_b = 1'b0; sv_b = 1'b0; adc_b = '0; tr_b = 1'b1;
    tick(2);
    rst = 1'b0;
    obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
    m_pkt[0] = 0; m_pkt[1] = 0;
  endtask

  function automatic logic [107:0] rand_set();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[107:0];
  endfunction

  task automatic strobe(input bit sel, input logic [107:0] raw);
    if (sel) begin adc_b = raw; sv_b = 1'b1; end
    else begin adc_a = raw[71:0]; sv_a = 1'b1; end
    tick();
    sv_a = 1'b0; sv_b = 1'b0;
  endtask

  // Model: each channel sign-extended into its 32-bit lane, four lanes per beat.
  task automatic model_accept(input bit sel, input logic [107:0] raw);
    int nch, nb, ch, v;
    logic [127:0] beat;
    logic [17:0] s;
    logic [144:0] e;
    nch = sel ? 6 : 4;
    nb = (nch + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      beat = '0;
      for (int l = 0; l < 4; l++) begin
        ch = 4 * b + l;
        if (ch < nch) begin
          s = raw[18*ch +: 18];
          v = $signed(s);
          beat[32*l +: 32] = v;
        end
      end
      e = {(b == nb - 1) && (m_pkt[sel] == P - 1), 16'hFFFF, beat};
      if (sel) exp_b.push_back(e); else exp_a.push_back(e);
    end
    m_pkt[sel] = (m_pkt[sel] + 1) % P;
  endtask

  task automatic model_term(input bit sel);
    if (m_pkt[sel] != 0) begin
      if (sel) exp_b.push_back({1'b1, 16'hFFFF, 128'h0});
      else exp_a.push_back({1'b1, 16'hFFFF, 128'h0});
    end
    m_pkt[sel] = 0;
  endtask

  task automatic drain(input bit sel);
    int n;
    n = 0;
    while (n < 300 && (sel ? (obs_b.size() < exp_b.size()) : (obs_a.size() < exp_a.size()))) begin
      tick();
      n++;
    end
    tick(4);
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++; if (tv_a !== 1'b0 || tv_b !== 1'b0) begin failures++; $display("FAIL reset_tvalid got %b%b want 00", tv_a, tv_b); end
    checks++; if (td_a !== '0 || tk_a !== '0 || tl_a !== 1'b0) begin failures++; $display("FAIL reset_axis_a got %h/%h/%b want 0", td_a, tk_a, tl_a); end
    checks++; if (td_b !== '0 || tk_b !== '0 || tl_b !== 1'b0) begin failures++; $display("FAIL reset_axis_b got %h/%h/%b want 0", td_b, tk_b, tl_b); end
    checks++; if (ov_a !== 1'b0 || sc_a !== 32'd0 || ov_b !== 1'b0 || sc_b !== 32'd0) begin failures++; $display("FAIL reset_status got %b %0d %b %0d want 0", ov_a, sc_a, ov_b, sc_b); end
  endtask

  task automatic test_t1_basic();
    logic [107:0] raw;
    do_reset();
    acq_a = 1'b1;
    tick();
    raw = {36'h0, 18'h0, 18'd5, 18'h20000, 18'h1FFFF};
    for (int i = 0; i < 4; i++) begin
      strobe(0, raw);
      model_accept(0, raw);
      tick(2);
    end
    drain(0);
    checks++; if (obs_a.size() !== 4) begin failures++; $display("FAIL t1_count got %0d want 4", obs_a.size()); end
    if (obs_a.size() > 0) begin
      checks++; if (obs_a[0][127:0] !== 128'h0000_0000_0000_0005_FFFE_0000_0001_FFFF) begin failures++; $display("FAIL t1_beat0 got %h", obs_a[0][127:0]); end
    end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      checks++; if (obs_a[i] !== exp_a[i]) begin failures++; $display("FAIL t1_beat%0d got %h want %h", i, obs_a[i], exp_a[i]); end
    end
    checks++; if (sc_a !== 32'd4) begin failures++; $display("FAIL t1_sample_cnt got %0d want 4", sc_a); end
  endtask

  task automatic test_t2_six_channel();
    logic [107:0] raw;
    do_reset();
    acq_b = 1'b1;
    tick();
    raw = rand_set();
    strobe(1, raw);
    model_accept(1, raw);
    drain(1);
    checks++; if (obs_b.size() !== 2) begin failures++; $display("FAIL t2_count got %0d want 2", obs_b.size()); end
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      checks++; if (obs_b[i] !== exp_b[i]) begin failures++; $display("FAIL t2_beat%0d got %h want %h", i, obs_b[i], exp_b[i]); end
    end
    if (obs_b.size() == 2) begin
      checks++; if (obs_b[1][127:64] !== 64'h0) begin failures++; $display("FAIL t2_pad_lanes got %h want 0", obs_b[1][127:64]); end
      checks++; if (obs_b[0][143:128] !== 16'hFFFF || obs_b[1][143:128] !== 16'hFFFF) begin failures++; $display("FAIL t2_tkeep got %h %h want ffff", obs_b[0][143:128], obs_b[1][143:128]); end
    end
  endtask

  task automatic test_random_stream();
    logic [107:0] raw;
    int n;
    do_reset();
    acq_a = 1'b1;
    tick();
    n = $urandom_range(9, 14);
    for (int i = 0; i < n; i++) begin
      raw = rand_set();
      strobe(0, raw);
      model_accept(0, raw);
      for (int g = 0; g < int'($urandom_range(1, 4)); g++) begin
        tr_a = $urandom_range(0, 1);
        tick();
      end
    end
    tr_a = 1'b1;
    acq_a = 1'b0;
    model_term(0);
    drain(0);
    checks++; if (obs_a.size() !== exp_a.size()) begin failures++; $display("FAIL rnd_count got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      checks++; if (obs_a[i] !== exp_a[i]) begin failures++; $display("FAIL rnd_beat%0d got %h want %h", i, obs_a[i], exp_a[i]); end
    end
    checks++; if (sc_a !== 32'(n)) begin failures++; $display("FAIL rnd_sample_cnt got %0d want %0d", sc_a, n); end
  endtask

  task automatic test_t3_backpressure();
    logic [107:0] raw;
    do_reset();
    tr_a = 1'b0;
    acq_a = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      raw = rand_set();
      strobe(0, raw);
      if (i < 16) model_accept(0, raw);
      tick(2);
    end
    checks++; if (ov_a !== 1'b1) begin failures++; $display("FAIL t3_overflow got %b want 1", ov_a); end
    checks++; if (sc_a !== 32'd16) begin failures++; $display("FAIL t3_sample_cnt got %0d want 16", sc_a); end
    checks++; if (tv_a !== 1'b1) begin failures++; $display("FAIL t3_tvalid_held got %b want 1", tv_a); end
    tr_a = 1'b1;
    drain(0);
    checks++; if (obs_a.size() !== 16) begin failures++; $display("FAIL t3_count got %0d want 16", obs_a.size()); end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      checks++; if (obs_a[i] !== exp_a[i]) begin failures++; $display("FAIL t3_beat%0d got %h want %h", i, obs_a[i], exp_a[i]); end
    end
  endtask

  task automatic test_t4_terminate();
    logic [107:0] raw;
    do_reset();
    acq_a = 1'b1;
    tick();
    raw = rand_set();
    strobe(0, raw);
    model_accept(0, raw);
    strobe(0, rand_set());
    tick(2);
    raw = rand_set();
    strobe(0, raw);
    model_accept(0, raw);
    tick(2);
    checks++; if (ov_a !== 1'b1 || sc_a !== 32'd2) begin failures++; $display("FAIL t4_pre_status got %b %0d want 1 2", ov_a, sc_a); end
    acq_a = 1'b0;
    model_term(0);
    tick(4);
    acq_a = 1'b1;
    tick();
    checks++; if (ov_a !== 1'b0 || sc_a !== 32'd0) begin failures++; $display("FAIL t4_rise_clear got %b %0d want 0 0", ov_a, sc_a); end
    for (int i = 0; i < 4; i++) begin
      raw = rand_set();
      strobe(0, raw);
      model_accept(0, raw);
      tick(2);
    end
    drain(0);
    checks++; if (obs_a.size() !== 7) begin failures++; $display("FAIL t4_count got %0d want 7", obs_a.size()); end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      checks++; if (obs_a[i] !== exp_a[i]) begin failures++; $display("FAIL t4_beat%0d got %h want %h", i, obs_a[i], exp_a[i]); end
    end
    checks++; if (sc_a !== 32'd4) begin failures++; $display("FAIL t4_sample_cnt got %0d want 4", sc_a); end
  endtask

  task automatic test_t5_back_to_back();
    logic [107:0] raw;
    do_reset();
    acq_b = 1'b1;
    tick();
    raw = rand_set();
    strobe(1, raw);
    model_accept(1, raw);
    strobe(1, rand_set());
    tick(3);
    for (int i = 0; i < 3; i++) begin
      raw = rand_set();
      strobe(1, raw);
      model_accept(1, raw);
      tick($urandom_range(2, 4));
    end
    drain(1);
    checks++; if (ov_b !== 1'b1) begin failures++; $display("FAIL t5_overflow got %b want 1", ov_b); end
    checks++; if (sc_b !== 32'd4) begin failures++; $display("FAIL t5_sample_cnt got %0d want 4", sc_b); end
    checks++; if (obs_b.size() !== exp_b.size()) begin failures++; $display("FAIL t5_count got %0d want %0d", obs_b.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      checks++; if (obs_b[i] !== exp_b[i]) begin failures++; $display("FAIL t5_beat%0d got %h want %h", i, obs_b[i], exp_b[i]); end
    end
  endtask

  task automatic test_t6_reset_mid_set();
    do_reset();
    tr_b = 1'b0;
    acq_b = 1'b1;
    tick();
    strobe(1, rand_set());
    tick(4);
    strobe(1, rand_set());
    strobe(1, rand_set());
    checks++; if (tv_b !== 1'b1 || ov_b !== 1'b1 || sc_b !== 32'd1) begin failures++; $display("FAIL t6_pre_status got %b %b %0d want 1 1 1", tv_b, ov_b, sc_b); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (tv_b !== 1'b0) begin failures++; $display("FAIL t6_tvalid got %b want 0", tv_b); end
    checks++; if (ov_b !== 1'b0 || sc_b !== 32'd0) begin failures++; $display("FAIL t6_status got %b %0d want 0 0", ov_b, sc_b); end
    tick(3);
    checks++; if (tv_b !== 1'b0) begin failures++; $display("FAIL t6_no_term got %b want 0", tv_b); end
  endtask

  initial begin
    test_reset();
    test_t1_basic();
    test_t2_six_channel();
    test_random_stream();
    test_t3_backpressure();
    test_t4_terminate();
    test_t5_back_to_back();
    test_t6_reset_mid_set();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
